// File: rtl/core_mem_arbiter_pkg.sv
// Shared types for the core memory arbiter: FSM states, port owner encoding
// and default bus widths.
package core_mem_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/core_mem_arbiter_if.sv
// Fetch, load/store and memory-bus signals of the arbiter; slave is the
// arbiter's view, master is the surrounding pipeline/bus view.
interface core_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_busy;
    logic              i_done;
    logic [DATA_W-1:0] i_rdata;
    logic              i_err;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [STRB_W-1:0] d_wstrb;
    logic              d_busy;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    logic              m_valid;
    logic              m_ready;
    logic [ADDR_W-1:0] m_addr;
    logic              m_we;
    logic [DATA_W-1:0] m_wdata;
    logic [STRB_W-1:0] m_wstrb;
    logic              m_rvalid;
    logic [DATA_W-1:0] m_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_busy, i_done, i_rdata, i_err,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        output d_busy, d_done, d_rdata, d_err,
        output m_valid, m_addr, m_we, m_wdata, m_wstrb,
        input  m_ready, m_rvalid, m_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_busy, i_done, i_rdata, i_err,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  d_busy, d_done, d_rdata, d_err,
        input  m_valid, m_addr, m_we, m_wdata, m_wstrb,
        output m_ready, m_rvalid, m_rdata
    );

endinterface

// File: rtl/core_mem_arb_pick.sv
// Grant selection with fixed DMEM priority and a starvation guard that hands
// the bus to fetch after STARVE_MAX consecutive DMEM wins.
module core_mem_arb_pick
    import core_mem_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic   clk,
    input  logic   nrst,
    input  logic   i_req,
    input  logic   d_req,
    input  logic   arb_en,
    output logic   grant,
    output owner_e grant_owner
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant       = arb_en & (i_req | d_req);
        grant_owner = OWN_D;
        if (i_req && (!d_req || starve_cnt == CNT_MAX)) begin
            grant_owner = OWN_I;
        end
    end

    // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            starve_cnt <= '0;
        end else if (grant) begin
            if (grant_owner == OWN_I || !i_req) begin
                starve_cnt <= '0;
            end else if (starve_cnt != CNT_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/core_mem_arbiter.sv
// Shares one single-ported memory bus between instruction fetch and load/store,
// producing per-port BUSY/DONE for the hazard unit.
module core_mem_arbiter
    import core_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input logic               clk,
    input logic               nrst,
    core_mem_arbiter_if.slave bus
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned TO_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

    state_e            state_q, state_d;
    owner_e            owner_q, grant_owner;
    logic              grant, arb_en;
    logic [TO_W-1:0]   to_cnt;
    logic              to_hit, resp_ok, resp_to;
    logic              i_done_w, d_done_w;

    logic [ADDR_W-1:0] m_addr_q;
    logic              m_we_q;
    logic [DATA_W-1:0] m_wdata_q;
    logic [STRB_W-1:0] m_wstrb_q;
    logic [DATA_W-1:0] i_rdata_q, d_rdata_q;
    logic              err_q;

    assign arb_en = (state_q == IDLE);

    core_mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clk         (clk),
        .nrst        (nrst),
        .i_req       (bus.i_req),
        .d_req       (bus.d_req),
        .arb_en      (arb_en),
        .grant       (grant),
        .grant_owner (grant_owner)
    );

    // The timeout counter runs from CMD entry, so a slow M_READY eats into the response budget.
    assign to_hit  = (TIMEOUT != 0) && (to_cnt >= TO_LAST);
    assign resp_ok = (state_q == RESP) && bus.m_rvalid;
    assign resp_to = (state_q == RESP) && !bus.m_rvalid && to_hit;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (grant) state_d = CMD;
            CMD:  if (bus.m_ready) state_d = RESP;
            RESP: if (resp_ok || resp_to) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            owner_q <= OWN_I;
            to_cnt  <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                owner_q <= grant_owner;
                to_cnt  <= '0;
            end else if ((state_q == CMD || state_q == RESP) && to_cnt < TO_LAST) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    // Command fields are captured at grant and held untouched through CMD.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_addr_q  <= '0;
            m_we_q    <= 1'b0;
            m_wdata_q <= '0;
            m_wstrb_q <= '0;
        end else if (grant) begin
            if (grant_owner == OWN_D) begin
                m_addr_q  <= bus.d_addr;
                m_we_q    <= bus.d_we;
                m_wdata_q <= bus.d_wdata;
                m_wstrb_q <= bus.d_we ? bus.d_wstrb : '0;
            end else begin
                m_addr_q  <= bus.i_addr;
                m_we_q    <= 1'b0;
                m_wdata_q <= '0;
                m_wstrb_q <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            err_q     <= 1'b0;
        end else if (resp_ok || resp_to) begin
            err_q <= resp_to;
            if (owner_q == OWN_D) begin
                d_rdata_q <= resp_ok ? bus.m_rdata : '0;
            end else begin
                i_rdata_q <= resp_ok ? bus.m_rdata : '0;
            end
        end
    end

    assign i_done_w = (state_q == DONE) && (owner_q == OWN_I);
    assign d_done_w = (state_q == DONE) && (owner_q == OWN_D);

    // BUSY is combinational so the stall asserts in the same cycle REQ rises.
    assign bus.i_busy  = (bus.i_req | (owner_q == OWN_I && state_q != IDLE)) & ~i_done_w;
    assign bus.d_busy  = (bus.d_req | (owner_q == OWN_D && state_q != IDLE)) & ~d_done_w;
    assign bus.i_done  = i_done_w;
    assign bus.d_done  = d_done_w;
    assign bus.i_err   = i_done_w & err_q;
    assign bus.d_err   = d_done_w & err_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;

    assign bus.m_valid = (state_q == CMD);
    assign bus.m_addr  = m_addr_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.m_wstrb = m_wstrb_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter: table-driven single transactions plus
// hand-written starvation, reset-in-flight and spurious-response sequences.
module tb_core_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SM = 4;
    localparam int unsigned TO = 8;

    logic clk;
    logic nrst;
    int   n_run;
    int   n_fail;

    core_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    core_mem_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .STARVE_MAX (SM),
        .TIMEOUT    (TO)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          ready_dly;
        int          rvalid_dly;
        logic [31:0] rdata;
        int          exp_lat;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_m_we;
        logic [3:0]  exp_m_wstrb;
        logic [31:0] exp_m_wdata;
    } vec_t;

    vec_t vecs [8];

    task automatic idle_bus();
        bus.m_ready  = 1'b0;
        bus.m_rvalid = 1'b0;
        bus.m_rdata  = 32'h5A5A5A5A;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit          resp_phase, seen_done, busy_ok, fields_ok, other_done;
        int          cmd_cnt, resp_cnt, n_valid, lat;
        logic [31:0] got_rdata;
        logic        got_err, my_busy, my_done;
        string       tag;
        tag = $sformatf("vec%0d", idx);
        resp_phase = 0; seen_done = 0; busy_ok = 1; fields_ok = 1; other_done = 0;
        cmd_cnt = 0; resp_cnt = 0; n_valid = 0; lat = -1;
        got_rdata = '0; got_err = 1'b0;
        @(negedge clk);
        if (v.is_d) begin
            bus.d_req = 1'b1; bus.d_we = v.we; bus.d_addr = v.addr;
            bus.d_wdata = v.wdata; bus.d_wstrb = v.wstrb;
        end else begin
            bus.i_req = 1'b1; bus.i_addr = v.addr;
        end
        for (int k = 0; k < 40 && !seen_done; k++) begin
            if (k > 0) @(negedge clk);
            idle_bus();
            if (resp_phase) begin
                if (resp_cnt == v.rvalid_dly) begin
                    bus.m_rvalid = 1'b1;
                    bus.m_rdata  = v.rdata;
                end
                resp_cnt++;
            end else if (bus.m_valid) begin
                if (cmd_cnt >= v.ready_dly) begin
                    bus.m_ready = 1'b1;
                    resp_phase  = 1;
                end
                cmd_cnt++;
            end
            #1;
            my_busy = v.is_d ? bus.d_busy : bus.i_busy;
            my_done = v.is_d ? bus.d_done : bus.i_done;
            if ((v.is_d ? bus.i_done : bus.d_done) !== 1'b0) other_done = 1;
            if (my_busy !== (k < v.exp_lat)) busy_ok = 0;
            if (bus.m_valid) begin
                n_valid++;
                if (bus.m_addr !== v.addr || bus.m_we !== v.exp_m_we ||
                    bus.m_wdata !== v.exp_m_wdata || bus.m_wstrb !== v.exp_m_wstrb)
                    fields_ok = 0;
            end
            if (my_done === 1'b1) begin
                seen_done = 1;
                lat       = k;
                got_rdata = v.is_d ? bus.d_rdata : bus.i_rdata;
                got_err   = v.is_d ? bus.d_err : bus.i_err;
            end
        end
        check({tag, " done latency"}, lat, v.exp_lat);
        check({tag, " rdata"}, got_rdata, v.exp_rdata);
        check({tag, " err"}, got_err, v.exp_err);
        check({tag, " busy profile ok"}, busy_ok, 1);
        check({tag, " cmd fields ok"}, fields_ok, 1);
        check({tag, " m_valid cycles"}, n_valid, v.ready_dly + 1);
        check({tag, " other port done"}, other_done, 0);
        @(negedge clk);
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        idle_bus();
    endtask

    initial begin
        logic [1:0] got_own [10];
        logic       exp_own [10];
        int         n_done, last_c;
        bit         busy_ok;

        n_run = 0; n_fail = 0;
        clk = 1'b0; nrst = 1'b0;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_wstrb = '0;
        idle_bus();

        //                  is_d we   addr          wdata         strb  rdy rv  rdata         lat exp_rdata     err  mwe  mstrb mwdata
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,        4'h0, 0,  1,  32'hDEAD_BEEF, 4,  32'hDEAD_BEEF, 1'b0, 1'b0, 4'h0, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_2000, 32'h1234_5678, 4'h3, 3,  0,  32'h0000_ACED, 6,  32'h0000_ACED, 1'b0, 1'b1, 4'h3, 32'h1234_5678};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,        4'h0, 0,  0,  32'hCAFE_F00D, 3,  32'hCAFE_F00D, 1'b0, 1'b0, 4'h0, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,        4'h0, 1,  2,  32'h0BAD_F00D, 6,  32'h0BAD_F00D, 1'b0, 1'b0, 4'h0, 32'h0};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_3000, 32'h0,        4'h0, 0,  99, 32'h0,        9,  32'h0,        1'b1, 1'b0, 4'h0, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_3004, 32'h0,        4'h0, 0,  0,  32'h1122_3344, 3,  32'h1122_3344, 1'b0, 1'b0, 4'h0, 32'h0};
        vecs[6] = '{1'b0, 1'b0, 32'h0000_0200, 32'h0,        4'h0, 2,  99, 32'h0,        9,  32'h0,        1'b1, 1'b0, 4'h0, 32'h0};
        vecs[7] = '{1'b1, 1'b1, 32'h0000_0010, 32'hFFFF_0000, 4'hF, 0,  3,  32'h0000_0001, 6,  32'h0000_0001, 1'b0, 1'b1, 4'hF, 32'hFFFF_0000};

        #1;
        check("reset m_valid/m_we/dones/errs/busy",
              {bus.m_valid, bus.m_we, bus.i_done, bus.d_done, bus.i_err, bus.d_err, bus.i_busy, bus.d_busy}, 0);
        check("reset m_addr/m_wdata", {bus.m_addr, bus.m_wdata}, 0);
        check("reset rdata/m_wstrb", {bus.i_rdata[27:0], bus.d_rdata[27:0], bus.m_wstrb}, 0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Both requesters held: expect D,D,D,D,I repeating, one issue every 4 cycles.
        exp_own = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 10; i++) got_own[i] = 2'd2;
        n_done = 0; last_c = -1; busy_ok = 1;
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_addr = 32'h500;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h600;
        bus.m_ready = 1'b1; bus.m_rvalid = 1'b1; bus.m_rdata = 32'h1;
        for (int c = 0; c < 60 && n_done < 10; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (bus.i_busy !== ~bus.i_done || bus.d_busy !== ~bus.d_done) busy_ok = 0;
            if (bus.i_done === 1'b1 || bus.d_done === 1'b1) begin
                got_own[n_done] = {1'b0, bus.d_done};
                n_done++;
                last_c = c;
            end
        end
        for (int i = 0; i < 10; i++)
            check($sformatf("starve grant %0d is dmem", i), got_own[i], {1'b0, exp_own[i]});
        check("starve busy held until own done", busy_ok, 1);
        check("starve tenth done cycle", last_c, 39);
        @(negedge clk);
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        idle_bus();

        // Reset while a store waits in RESP, then a stray response after release.
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h7000;
        bus.d_wdata = 32'hFEED_FACE; bus.d_wstrb = 4'hF;
        @(negedge clk);
        bus.m_ready = 1'b1;
        @(negedge clk);
        bus.m_ready = 1'b0;
        #1;
        check("pre-reset in RESP: valid low, busy high", {bus.m_valid, bus.d_busy}, 2'b01);
        nrst = 1'b0;
        bus.d_req = 1'b0;
        #1;
        check("reset in flight ctrl outs",
              {bus.m_valid, bus.m_we, bus.i_done, bus.d_done, bus.i_err, bus.d_err, bus.i_busy, bus.d_busy}, 0);
        check("reset in flight m_addr/m_wdata", {bus.m_addr, bus.m_wdata}, 0);
        check("reset in flight i/d rdata", {bus.i_rdata, bus.d_rdata}, 0);
        check("reset in flight m_wstrb", bus.m_wstrb, 0);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        bus.m_rvalid = 1'b1; bus.m_rdata = 32'h9999_9999;
        busy_ok = 1;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 1) idle_bus();
            #1;
            if ({bus.m_valid, bus.i_done, bus.d_done, bus.i_busy, bus.d_busy} !== 5'b0 ||
                bus.d_rdata !== 32'h0)
                busy_ok = 1;
            else
                continue;
            busy_ok = 0;
        end
        check("post-reset stray rvalid ignored", busy_ok, 1);

        // Stray response in IDLE, then a fetch whose REQ drops during CMD.
        @(negedge clk);
        bus.m_rvalid = 1'b1; bus.m_rdata = 32'h7777_7777;
        #1;
        check("idle stray rvalid no done", {bus.i_done, bus.d_done, bus.m_valid}, 0);
        @(negedge clk);
        idle_bus();
        #1;
        check("idle stray rvalid no capture", bus.i_rdata, 0);
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_addr = 32'h400;
        @(negedge clk);
        #1;
        check("drop seq cmd valid/addr", {bus.m_valid, bus.m_addr}, {1'b1, 32'h400});
        bus.i_req = 1'b0;
        #1;
        check("drop seq busy after req drop", bus.i_busy, 1);
        @(negedge clk);
        bus.m_ready = 1'b1;
        @(negedge clk);
        bus.m_ready = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'h600D_CAFE;
        @(negedge clk);
        idle_bus();
        #1;
        check("drop seq done/err", {bus.i_done, bus.i_err, bus.i_busy}, 3'b100);
        check("drop seq rdata", bus.i_rdata, 32'h600D_CAFE);
        @(negedge clk);
        #1;
        check("drop seq no regrant", {bus.i_done, bus.m_valid, bus.i_busy}, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
- Shares one single-ported memory bus between the instruction-fetch requester (IMEM, read-only) and the load/store requester (DMEM, read/write).
- Generates the per-port BUSY/DONE signals that the hazard control unit consumes for stalling.
- Uses fixed DMEM priority, with a starvation guard so fetch always makes progress.
- Sits between the pipeline's fetch/mem stages and the memory/bus interface.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; DATA_W/8 byte strobes.
- STARVE_MAX, 4, consecutive DMEM grants allowed while IMEM waits (>=1).
- TIMEOUT, 255, cycles to wait for M_RVALID before error completion; 0 disables.

Ports:
- CLK  in  1  clock; one clock domain.
- NRST  in  1  reset; asynchronous, active-low.
- I_REQ  in  1  fetch request, level, held until I_DONE.
- I_ADDR  in  ADDR_W  fetch address, stable while I_REQ.
- I_BUSY  out  1  fetch not complete; stall.
- I_DONE  out  1  one-cycle completion pulse.
- I_RDATA  out  DATA_W  fetched word, valid with I_DONE.
- I_ERR  out  1  timeout flag, valid with I_DONE.
- D_REQ  in  1  data request, level, held until D_DONE.
- D_WE  in  1  1=store, 0=load.
- D_ADDR  in  ADDR_W  data address.
- D_WDATA  in  DATA_W  store data.
- D_WSTRB  in  DATA_W/8  store byte enables.
- D_BUSY  out  1  data access not complete.
- D_DONE  out  1  one-cycle completion pulse.
- D_RDATA  out  DATA_W  load data, valid with D_DONE.
- D_ERR  out  1  timeout flag, valid with D_DONE.
- M_VALID  out  1  bus command valid.
- M_READY  in  1  bus command accepted.
- M_ADDR  out  ADDR_W  command address.
- M_WE  out  1  command is write.
- M_WDATA  out  DATA_W  write data.
- M_WSTRB  out  DATA_W/8  write strobes (0 for reads).
- M_RVALID  in  1  response/ack; one pulse per command, reads and writes.
- M_RDATA  in  DATA_W  read data, valid with M_RVALID.

Behaviour:
- Reset (async, NRST=0):
  - state IDLE, starve counter 0, timeout counter 0.
  - M_VALID, M_WE, I_DONE, D_DONE, I_ERR, D_ERR = 0.
  - M_ADDR/M_WDATA/M_WSTRB/I_RDATA/D_RDATA = 0.
  - A transaction in flight at reset is abandoned; a late M_RVALID after reset is ignored in IDLE.
- FSM states: IDLE, CMD, RESP, DONE.
- IDLE: arbitrate among requests not in their DONE cycle.
  - Only D_REQ -> DMEM; only I_REQ -> IMEM.
  - Both -> DMEM, unless starve_cnt==STARVE_MAX, then IMEM.
  - Grant latches owner, address, WE, WDATA, WSTRB (IMEM: WE=0, WSTRB=0) into M_* registers; go to CMD.
- CMD: M_VALID=1; command fields held stable until M_READY sampled high; then M_VALID=0 next cycle and go to RESP. M_READY already high on first CMD cycle means one-cycle command.
- RESP: wait for M_RVALID.
  - On M_RVALID: register M_RDATA into owner's RDATA, pulse owner DONE next cycle (state DONE), ERR=0.
  - If TIMEOUT!=0 and the counter, started on entry to CMD, reaches TIMEOUT: DONE with ERR=1 and RDATA=0.
- DONE: single cycle, owner DONE=1; return to IDLE; re-arbitration happens in IDLE the next cycle. Back-to-back transaction issue-to-issue minimum is 4 cycles.
- M_RVALID in IDLE/CMD/DONE is ignored.
- Starve counter:
  - Increments on DMEM grant while I_REQ=1, saturating at STARVE_MAX.
  - Clears on IMEM grant, or on DMEM grant with I_REQ=0.
- BUSY (combinational, for same-cycle stall): X_BUSY = (X_REQ | owner==X & state!=IDLE) & ~X_DONE. Goes high the same cycle REQ rises; low in the DONE cycle.
- Requester may deassert or re-raise REQ the cycle after DONE.
- A REQ dropped mid-transaction does not abort; completion still pulses DONE.
- Simultaneous I_REQ/D_REQ rise in IDLE: the losing port's BUSY stays high until its own DONE.

Decomposition:
- Package core_mem_pkg: FSM state localparams (IDLE/CMD/RESP/DONE), owner encoding (OWN_I, OWN_D), default widths.
- One natural sub-module: core_mem_arb_pick. Combinational grant selection plus the starve counter register, taking I_REQ, D_REQ, and an arbitrate strobe.

Test Plan:
- Single IMEM read at 0x100, M_READY=1 immediately, M_RVALID two cycles later with data 0xDEADBEEF -> I_DONE pulses one cycle, I_RDATA=0xDEADBEEF, I_BUSY high from REQ cycle until DONE cycle.
- DMEM store addr 0x2000, wdata 0x12345678, strobe 0x3 -> M_WE=1, M_WSTRB=0x3; M_VALID held 3 cycles while M_READY=0, fields stable; D_DONE after M_RVALID.
- I_REQ and D_REQ held continuously, STARVE_MAX=4 -> grant order D,D,D,D,I,D,D,D,D,I…
- TIMEOUT=8, no M_RVALID on DMEM load -> D_DONE with D_ERR=1, D_RDATA=0, 8 cycles after CMD entry; next request proceeds normally.
- NRST asserted during RESP, then released, then spurious M_RVALID -> all outputs 0, no DONE, state IDLE.
- Spurious M_RVALID in IDLE, plus I_REQ drop during CMD -> no effect from the spurious pulse; the in-flight fetch still completes with I_DONE.
